// File: rtl/intersection_pkg.sv
// Shared types for the intersection phase sequencer.
// State encoding, return direction and dwell-timer width.
package intersection_pkg;

  localparam int TIMER_W = 8;

  typedef enum logic [2:0] {
    AR_NS,
    NS_G,
    NS_Y,
    AR_EW,
    EW_G,
    EW_Y,
    WALK
  } state_t;

  typedef enum logic {
    NS,
    EW
  } dir_t;

endpackage

// File: rtl/tick_gen.sv
// One-cycle timing strobe derived from clk_50.
// Pulses when the free-running count reaches TICK_DIV-1.
module tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk_50,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/intersection_ctrl.sv
// Two-road intersection sequencer with pedestrian crossing.
// Lamps are registered from next-state so they move with the state.
module intersection_ctrl
  import intersection_pkg::*;
#(
  parameter int TICK_DIV    = 50_000_000,
  parameter int T_MIN_GREEN = 10,
  parameter int T_EW_GREEN  = 8,
  parameter int T_YELLOW    = 3,
  parameter int T_ALL_RED   = 1,
  parameter int T_WALK      = 6
) (
  input  logic clk_50,
  input  logic rst_n,
  input  logic ped_btn,
  input  logic car_ew,
  output logic ns_red,
  output logic ns_yellow,
  output logic ns_green,
  output logic ew_red,
  output logic ew_yellow,
  output logic ew_green,
  output logic walk,
  output logic ped_wait
);

  localparam int EW_ = TIMER_W + 1;
  localparam logic [EW_-1:0] MIN_G = EW_'(T_MIN_GREEN);
  localparam logic [EW_-1:0] EW_GR = EW_'(T_EW_GREEN);
  localparam logic [EW_-1:0] YEL   = EW_'(T_YELLOW);
  localparam logic [EW_-1:0] ALL_R = EW_'(T_ALL_RED);
  localparam logic [EW_-1:0] WLK   = EW_'(T_WALK);

  logic tick;
  logic ped_s1, ped_s2, ped_q;
  logic car_s1, car_s;
  logic ped_pending;
  logic ped_rise;
  state_t state, nxt;
  dir_t ret_dir, nret;
  logic [TIMER_W-1:0] timer;
  logic [EW_-1:0] elapsed;
  logic demand;

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk_50(clk_50),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign ped_rise = ped_s2 & ~ped_q;
  assign elapsed  = {1'b0, timer} + EW_'(1);
  assign demand   = car_s | ped_pending;
  assign ped_wait = ped_pending;

  always_comb begin
    nxt  = state;
    nret = ret_dir;
    if (tick) begin
      unique case (state)
        AR_NS: if (elapsed >= ALL_R) begin
          nxt  = ped_pending ? WALK : NS_G;
          nret = NS;
        end
        NS_G: if (elapsed >= MIN_G && demand) nxt = NS_Y;
        NS_Y: if (elapsed >= YEL) nxt = AR_EW;
        AR_EW: if (elapsed >= ALL_R) begin
          nxt  = ped_pending ? WALK : EW_G;
          nret = EW;
        end
        EW_G: if (elapsed >= EW_GR) nxt = EW_Y;
        EW_Y: if (elapsed >= YEL) nxt = AR_NS;
        WALK: if (elapsed >= WLK) begin
          nxt = (ret_dir == NS) ? NS_G : EW_G;
        end
        default: nxt = AR_NS;
      endcase
    end
  end

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      ped_s1      <= 1'b0;
      ped_s2      <= 1'b0;
      ped_q       <= 1'b0;
      car_s1      <= 1'b0;
      car_s       <= 1'b0;
      ped_pending <= 1'b0;
      state       <= AR_NS;
      ret_dir     <= NS;
      timer       <= '0;
      ns_red      <= 1'b1;
      ns_yellow   <= 1'b0;
      ns_green    <= 1'b0;
      ew_red      <= 1'b1;
      ew_yellow   <= 1'b0;
      ew_green    <= 1'b0;
      walk        <= 1'b0;
    end else begin
      ped_s1  <= ped_btn;
      ped_s2  <= ped_s1;
      ped_q   <= ped_s2;
      car_s1  <= car_ew;
      car_s   <= car_s1;
      state   <= nxt;
      ret_dir <= nret;
      if (nxt != state) begin
        timer <= '0;
      end else if (tick && timer != '1) begin
        timer <= timer + TIMER_W'(1);
      end
      // Entering WALK services the request; a same-cycle press is absorbed.
      if (nxt == WALK && state != WALK) begin
        ped_pending <= 1'b0;
      end else if (state != WALK && ped_rise) begin
        ped_pending <= 1'b1;
      end
      ns_red    <= !(nxt == NS_G || nxt == NS_Y);
      ns_yellow <= (nxt == NS_Y);
      ns_green  <= (nxt == NS_G);
      ew_red    <= !(nxt == EW_G || nxt == EW_Y);
      ew_yellow <= (nxt == EW_Y);
      ew_green  <= (nxt == EW_G);
      walk      <= (nxt == WALK);
    end
  end

endmodule

// File: tb/tb_intersection_ctrl.sv
// Directed phase-sequence bench for intersection_ctrl.
// Expected lamp phases are queued, then drained cycle by cycle.
module tb_intersection_ctrl;

  logic clk_50 = 1'b0;
  logic rst_n;
  logic ped_btn;
  logic car_ew;
  logic ns_red, ns_yellow, ns_green;
  logic ew_red, ew_yellow, ew_green;
  logic walk, ped_wait;

  int checks = 0;
  int errors = 0;

  // {ns r,y,g, ew r,y,g, walk}
  localparam logic [6:0] L_AR  = 7'b100_100_0;
  localparam logic [6:0] L_NSG = 7'b001_100_0;
  localparam logic [6:0] L_NSY = 7'b010_100_0;
  localparam logic [6:0] L_EWG = 7'b100_001_0;
  localparam logic [6:0] L_EWY = 7'b100_010_0;
  localparam logic [6:0] L_WLK = 7'b100_100_1;

  typedef struct {
    string      tag;
    logic [7:0] exp;
    int         n;
  } phase_t;

  phase_t sb[$];

  intersection_ctrl #(
    .TICK_DIV   (4),
    .T_MIN_GREEN(3),
    .T_EW_GREEN (2),
    .T_YELLOW   (2),
    .T_ALL_RED  (1),
    .T_WALK     (2)
  ) dut (
    .clk_50   (clk_50),
    .rst_n    (rst_n),
    .ped_btn  (ped_btn),
    .car_ew   (car_ew),
    .ns_red   (ns_red),
    .ns_yellow(ns_yellow),
    .ns_green (ns_green),
    .ew_red   (ew_red),
    .ew_yellow(ew_yellow),
    .ew_green (ew_green),
    .walk     (walk),
    .ped_wait (ped_wait)
  );

  always #5 clk_50 = ~clk_50;

  function automatic logic [7:0] lamps();
    return {ns_red, ns_yellow, ns_green,
            ew_red, ew_yellow, ew_green,
            walk, ped_wait};
  endfunction

  task automatic step();
    @(posedge clk_50);
    #1;
  endtask

  task automatic push(input string tag,
                      input logic [6:0] l,
                      input logic w,
                      input int n);
    phase_t p;
    p.tag = tag;
    p.exp = {l, w};
    p.n   = n;
    sb.push_back(p);
  endtask

  task automatic drain();
    phase_t p;
    logic [7:0] obs;
    while (sb.size() > 0) begin
      p = sb.pop_front();
      for (int i = 0; i < p.n; i++) begin
        obs = lamps();
        checks++;
        assert (obs === p.exp) else begin
          errors++;
          $error("FAIL %s cyc %0d observed %b expected %b",
                 p.tag, i, obs, p.exp);
        end
        step();
      end
    end
  endtask

  task automatic do_reset();
    logic [7:0] obs;
    rst_n = 1'b0;
    #1;
    obs = lamps();
    checks++;
    assert (obs === {L_AR, 1'b0}) else begin
      errors++;
      $error("FAIL reset observed %b expected %b",
             obs, {L_AR, 1'b0});
    end
    repeat (2) @(posedge clk_50);
    @(negedge clk_50);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n   = 1'b1;
    ped_btn = 1'b0;
    car_ew  = 1'b0;
    #2;

    // 1: no demand, NS green rests
    do_reset();
    push("s1_arns", L_AR, 0, 4);
    push("s1_nsg", L_NSG, 0, 200);
    drain();

    // 2: EW car held from reset
    car_ew = 1'b1;
    do_reset();
    push("s2_arns", L_AR, 0, 4);
    push("s2_nsg", L_NSG, 0, 12);
    push("s2_nsy", L_NSY, 0, 8);
    push("s2_arew", L_AR, 0, 4);
    push("s2_ewg", L_EWG, 0, 8);
    push("s2_ewy", L_EWY, 0, 8);
    push("s2_arns2", L_AR, 0, 4);
    push("s2_nsg2", L_NSG, 0, 12);
    push("s2_nsy2", L_NSY, 0, 2);
    drain();

    // 3/4: ped press in NS_G, second press in WALK
    car_ew = 1'b0;
    do_reset();
    push("s3_arns", L_AR, 0, 4);
    push("s3_nsg", L_NSG, 0, 10);
    drain();
    ped_btn = 1'b1;
    push("s3_sync", L_NSG, 0, 2);
    drain();
    ped_btn = 1'b0;
    push("s3_sync2", L_NSG, 0, 1);
    push("s3_wait", L_NSG, 1, 3);
    push("s3_nsy", L_NSY, 1, 8);
    push("s3_arew", L_AR, 1, 4);
    push("s3_walk", L_WLK, 0, 3);
    drain();
    ped_btn = 1'b1;
    push("s4_walk", L_WLK, 0, 2);
    drain();
    ped_btn = 1'b0;
    push("s4_walk2", L_WLK, 0, 3);
    push("s4_ewg", L_EWG, 0, 8);
    push("s4_ewy", L_EWY, 0, 8);
    push("s4_arns", L_AR, 0, 4);
    push("s4_nsg", L_NSG, 0, 20);
    drain();

    // 5: ped edge on the AR_EW->WALK edge
    do_reset();
    push("s5_arns", L_AR, 0, 4);
    push("s5_nsg", L_NSG, 0, 2);
    drain();
    ped_btn = 1'b1;
    push("s5_sync", L_NSG, 0, 2);
    drain();
    ped_btn = 1'b0;
    push("s5_sync2", L_NSG, 0, 1);
    push("s5_wait", L_NSG, 1, 7);
    push("s5_nsy", L_NSY, 1, 8);
    push("s5_arew", L_AR, 1, 1);
    drain();
    ped_btn = 1'b1;
    push("s5_arew2", L_AR, 1, 3);
    push("s5_walk", L_WLK, 0, 3);
    drain();
    ped_btn = 1'b0;
    push("s5_walk2", L_WLK, 0, 5);
    push("s5_ewg", L_EWG, 0, 8);
    push("s5_ewy", L_EWY, 0, 8);
    push("s5_arns2", L_AR, 0, 4);
    push("s5_nsg2", L_NSG, 0, 8);
    drain();

    // 6: reset mid-EW_G with a pending request
    car_ew = 1'b1;
    do_reset();
    push("s6_arns", L_AR, 0, 4);
    push("s6_nsg", L_NSG, 0, 12);
    push("s6_nsy", L_NSY, 0, 8);
    push("s6_arew", L_AR, 0, 4);
    push("s6_ewg", L_EWG, 0, 2);
    drain();
    ped_btn = 1'b1;
    push("s6_ewg2", L_EWG, 0, 2);
    drain();
    ped_btn = 1'b0;
    push("s6_ewg3", L_EWG, 0, 1);
    push("s6_wait", L_EWG, 1, 1);
    drain();
    car_ew = 1'b0;
    do_reset();
    push("s6_arns2", L_AR, 0, 4);
    push("s6_nsg2", L_NSG, 0, 10);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
